// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the EX_MEM data-memory access stage: bus widths, op codes,
// FSM state encoding and small decode helpers.
package mem_access_unit_pkg;

    localparam int unsigned WORD_BUS     = 32;
    localparam int unsigned REG_ADDR_BUS = 5;

    typedef enum logic [2:0] {
        MemNone = 3'd0,
        MemLb   = 3'd1,
        MemLbu  = 3'd2,
        MemLh   = 3'd3,
        MemLhu  = 3'd4,
        MemLw   = 3'd5,
        MemSb   = 3'd6,
        MemSh   = 3'd7
    } mem_op_e;

    // SW reuses the LW code; a word op that does not write a register is a store.
    localparam logic [2:0] MemSw = MemLw;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} mem_size_e;

    typedef enum logic {StIdle, StReq} state_e;

    function automatic mem_size_e op_size(logic [2:0] op);
        case (op)
            MemLb, MemLbu, MemSb: return SzByte;
            MemLh, MemLhu, MemSh: return SzHalf;
            default:              return SzWord;
        endcase
    endfunction

    function automatic logic is_store(logic [2:0] op, logic reg_we);
        return (op == MemSb) || (op == MemSh) || ((op == MemSw) && !reg_we);
    endfunction

    function automatic logic is_misaligned(logic [2:0] op, logic [1:0] addr_lo);
        if (op == MemNone) return 1'b0;
        case (op_size(op))
            SzHalf:  return addr_lo[0];
            SzWord:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic                dmemReq;
    logic                dmemWe;
    logic [WORD_BUS-1:0] dmemAddr;
    logic [3:0]          dmemByteEnable;
    logic [WORD_BUS-1:0] dmemWdata;
    logic                dmemReady;
    logic [WORD_BUS-1:0] dmemRdata;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemByteEnable, dmemWdata,
        input  dmemReady, dmemRdata
    );

    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemByteEnable, dmemWdata,
        output dmemReady, dmemRdata
    );

endinterface

// File: rtl/mem_align.sv
// Little-endian lane logic: byte enables and replicated write data for stores,
// lane extraction with sign/zero extension for loads.
module mem_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]          op_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [WORD_BUS-1:0] store_data_i,
    input  logic [WORD_BUS-1:0] rdata_i,
    output logic [3:0]          byte_enable_o,
    output logic [WORD_BUS-1:0] wdata_o,
    output logic [WORD_BUS-1:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        byte_enable_o = 4'b1111;
        wdata_o       = store_data_i;
        unique case (op_size(op_i))
            SzByte: begin
                byte_enable_o = 4'b0001 << addr_lo_i;
                wdata_o       = {4{store_data_i[7:0]}};
            end
            SzHalf: begin
                byte_enable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o       = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data_o = rdata_i;
        case (op_i)
            MemLb:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            MemLbu:  load_data_o = {24'b0, byte_sel};
            MemLh:   load_data_o = {{16{half_sel[15]}}, half_sel};
            MemLhu:  load_data_o = {16'b0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls the pipe
// until memory completes, and registers the register-file writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inValid,
    input  logic [2:0]              inMemOp,
    input  logic [WORD_BUS-1:0]     inAddr,
    input  logic [WORD_BUS-1:0]     inStoreData,
    input  logic [REG_ADDR_BUS-1:0] inRegDest,
    input  logic                    inRegWriteEnable,
    mem_access_unit_if.master       dmem,
    output logic                    writeEnable,
    output logic [REG_ADDR_BUS-1:0] writeAddr,
    output logic [WORD_BUS-1:0]     writeResult,
    output logic                    stall,
    output logic                    addrError
);

    state_e state_q, state_d;

    logic [2:0]              op_q, op_d;
    logic                    store_q, store_d;
    logic [WORD_BUS-1:0]     addr_q, addr_d;
    logic [WORD_BUS-1:0]     data_q, data_d;
    logic [REG_ADDR_BUS-1:0] dest_q, dest_d;
    logic                    reg_we_q, reg_we_d;

    logic                    write_enable_q, write_enable_d;
    logic [REG_ADDR_BUS-1:0] write_addr_q, write_addr_d;
    logic [WORD_BUS-1:0]     write_result_q, write_result_d;
    logic                    addr_error_q, addr_error_d;

    logic                in_is_mem;
    logic                in_misaligned;
    logic [3:0]          align_be;
    logic [WORD_BUS-1:0] align_wdata;
    logic [WORD_BUS-1:0] align_load;

    assign in_is_mem     = inMemOp != MemNone;
    assign in_misaligned = is_misaligned(inMemOp, inAddr[1:0]);

    mem_align u_mem_align (
        .op_i          (op_q),
        .addr_lo_i     (addr_q[1:0]),
        .store_data_i  (data_q),
        .rdata_i       (dmem.dmemRdata),
        .byte_enable_o (align_be),
        .wdata_o       (align_wdata),
        .load_data_o   (align_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (inValid && in_is_mem && !in_misaligned) state_d = StReq;
            StReq:  if (dmem.dmemReady) state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q           <= MemNone;
            store_q        <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            dest_q         <= '0;
            reg_we_q       <= 1'b0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_result_q <= '0;
            addr_error_q   <= 1'b0;
        end else begin
            op_q           <= op_d;
            store_q        <= store_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            dest_q         <= dest_d;
            reg_we_q       <= reg_we_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_result_q <= write_result_d;
            addr_error_q   <= addr_error_d;
        end
    end

    always_comb begin
        op_d           = op_q;
        store_d        = store_q;
        addr_d         = addr_q;
        data_d         = data_q;
        dest_d         = dest_q;
        reg_we_d       = reg_we_q;
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_result_d = write_result_q;
        addr_error_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inValid) begin
                    if (!in_is_mem) begin
                        write_enable_d = inRegWriteEnable;
                        write_addr_d   = inRegDest;
                        write_result_d = inAddr;
                    end else if (in_misaligned) begin
                        addr_error_d = 1'b1;
                    end else begin
                        op_d     = inMemOp;
                        store_d  = is_store(inMemOp, inRegWriteEnable);
                        addr_d   = inAddr;
                        data_d   = inStoreData;
                        dest_d   = inRegDest;
                        reg_we_d = inRegWriteEnable;
                    end
                end
            end
            StReq: begin
                // Stores complete silently; the writeback registers keep their old contents.
                if (dmem.dmemReady && !store_q) begin
                    write_enable_d = reg_we_q;
                    write_addr_d   = dest_q;
                    write_result_d = align_load;
                end
            end
        endcase
    end

    always_comb begin
        dmem.dmemReq        = 1'b0;
        dmem.dmemWe         = 1'b0;
        dmem.dmemAddr       = '0;
        dmem.dmemByteEnable = 4'b0000;
        dmem.dmemWdata      = '0;
        stall               = 1'b0;
        unique case (state_q)
            StIdle: stall = inValid && in_is_mem && !in_misaligned;
            StReq: begin
                dmem.dmemReq        = 1'b1;
                dmem.dmemWe         = store_q;
                dmem.dmemAddr       = {addr_q[WORD_BUS-1:2], 2'b00};
                dmem.dmemByteEnable = align_be;
                dmem.dmemWdata      = align_wdata;
                stall               = !dmem.dmemReady;
            end
        endcase
        // Keep stall low while reset is held even if inValid is driven.
        stall = stall && rst;
    end

    assign writeEnable = write_enable_q;
    assign writeAddr   = write_addr_q;
    assign writeResult = write_result_q;
    assign addrError   = addr_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus reset/hold sequences,
// with writebacks checked through an expected-result queue.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_sdata;
    logic [4:0]  in_dest;
    logic        in_we;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_result;
    logic        stall;
    logic        addr_error;

    mem_access_unit_if dmem ();

    mem_access_unit dut (
        .clk              (clk),
        .rst              (rst),
        .inValid          (in_valid),
        .inMemOp          (in_op),
        .inAddr           (in_addr),
        .inStoreData      (in_sdata),
        .inRegDest        (in_dest),
        .inRegWriteEnable (in_we),
        .dmem             (dmem),
        .writeEnable      (write_enable),
        .writeAddr        (write_addr),
        .writeResult      (write_result),
        .stall            (stall),
        .addrError        (addr_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  dest;
        logic        we;
        int          delay;
        logic        mis;
        logic        store;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] result;
    } vec_t;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wres;
    } wb_t;

    vec_t vecs[$];
    wb_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Writeback monitor: every writeEnable pulse must match the oldest expected entry.
    always @(negedge clk) begin
        wb_t e;
        if (rst === 1'b1 && write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: writeEnable=1 addr %0d result %h, expected none",
                         write_addr, write_result);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", 32'(write_addr), 32'(e.waddr));
                check("wb_result", write_result, e.wres);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(dmem.dmemReq), 32'd0);
        check({tag, "_we"}, 32'(dmem.dmemWe), 32'd0);
        check({tag, "_addr"}, dmem.dmemAddr, 32'd0);
        check({tag, "_be"}, 32'(dmem.dmemByteEnable), 32'd0);
        check({tag, "_wdata"}, dmem.dmemWdata, 32'd0);
        check({tag, "_wen"}, 32'(write_enable), 32'd0);
        check({tag, "_waddr"}, 32'(write_addr), 32'd0);
        check({tag, "_wres"}, write_result, 32'd0);
        check({tag, "_aerr"}, 32'(addr_error), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    stalls;
        string t;
        stalls = 0;
        t = $sformatf("v%0d", idx);
        in_valid = 1'b1;
        in_op    = v.op;
        in_addr  = v.addr;
        in_sdata = v.sdata;
        in_dest  = v.dest;
        in_we    = v.we;
        dmem.dmemReady = 1'b0;
        #1;
        check({t, "_idle_stall"}, 32'(stall), 32'((v.op != 3'd0) && !v.mis));
        check({t, "_idle_req"}, 32'(dmem.dmemReq), 32'd0);
        if (stall) stalls++;
        if (v.op == 3'd0) begin
            if (v.we) exp_q.push_back('{v.dest, v.addr});
            @(posedge clk); #1;
            in_valid = 1'b0;
        end else if (v.mis) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({t, "_aerr_on"}, 32'(addr_error), 32'd1);
            check({t, "_mis_req"}, 32'(dmem.dmemReq), 32'd0);
            @(posedge clk); #1;
            check({t, "_aerr_off"}, 32'(addr_error), 32'd0);
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int c = 0; c <= v.delay; c++) begin
                check({t, "_req"}, 32'(dmem.dmemReq), 32'd1);
                check({t, "_we"}, 32'(dmem.dmemWe), 32'(v.store));
                check({t, "_addr"}, dmem.dmemAddr, {v.addr[31:2], 2'b00});
                check({t, "_be"}, 32'(dmem.dmemByteEnable), 32'(v.be));
                check({t, "_wdata"}, dmem.dmemWdata, v.wdata);
                if (c < v.delay) begin
                    if (stall) stalls++;
                    @(posedge clk); #1;
                end
            end
            dmem.dmemReady = 1'b1;
            dmem.dmemRdata = v.rdata;
            #1;
            check({t, "_ready_stall"}, 32'(stall), 32'd0);
            if (!v.store && v.we) exp_q.push_back('{v.dest, v.result});
            @(posedge clk); #1;
            dmem.dmemReady = 1'b0;
            dmem.dmemRdata = '0;
            check({t, "_done_req"}, 32'(dmem.dmemReq), 32'd0);
            check({t, "_stall_cycles"}, 32'(stalls), 32'(v.delay + 1));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // op addr sdata rdata dest we delay mis store be wdata result
        vecs.push_back('{3'd0, 32'h1234, 0, 0, 5'd5, 1'b1, 0, 0, 0, 4'h0, 0, 32'h1234});
        vecs.push_back('{3'd1, 32'h103, 0, 32'h80AABBCC, 5'd3, 1'b1, 0, 0, 0, 4'h8, 0, 32'hFFFFFF80});
        vecs.push_back('{3'd2, 32'h103, 0, 32'h80AABBCC, 5'd4, 1'b1, 0, 0, 0, 4'h8, 0, 32'h00000080});
        vecs.push_back('{3'd3, 32'h102, 0, 32'h80AABBCC, 5'd6, 1'b1, 1, 0, 0, 4'hC, 0, 32'hFFFF80AA});
        vecs.push_back('{3'd4, 32'h100, 0, 32'h1234F00D, 5'd7, 1'b1, 0, 0, 0, 4'h3, 0, 32'h0000F00D});
        vecs.push_back('{3'd3, 32'h100, 0, 32'h1234F00D, 5'd8, 1'b1, 2, 0, 0, 4'h3, 0, 32'hFFFFF00D});
        vecs.push_back('{3'd5, 32'h200, 0, 32'hDEADBEEF, 5'd9, 1'b1, 1, 0, 0, 4'hF, 0, 32'hDEADBEEF});
        vecs.push_back('{3'd1, 32'h101, 0, 32'h11227F33, 5'd10, 1'b1, 0, 0, 0, 4'h2, 0, 32'h7F});
        vecs.push_back('{3'd2, 32'h1FE, 0, 32'h00C30000, 5'd13, 1'b1, 0, 0, 0, 4'h4, 0, 32'hC3});
        vecs.push_back('{3'd6, 32'h42, 32'h123456A5, 0, 5'd0, 1'b0, 0, 0, 1, 4'h4, 32'hA5A5A5A5, 0});
        vecs.push_back('{3'd7, 32'h22, 32'h0000BEEF, 0, 5'd0, 1'b0, 3, 0, 1, 4'hC, 32'hBEEFBEEF, 0});
        vecs.push_back('{3'd5, 32'h300, 32'hCAFEF00D, 0, 5'd0, 1'b0, 2, 0, 1, 4'hF, 32'hCAFEF00D, 0});
        vecs.push_back('{3'd5, 32'h201, 0, 0, 5'd11, 1'b1, 0, 1, 0, 4'h0, 0, 0});
        vecs.push_back('{3'd3, 32'h103, 0, 0, 5'd12, 1'b1, 0, 1, 0, 4'h0, 0, 0});
        vecs.push_back('{3'd4, 32'h101, 0, 0, 5'd12, 1'b1, 0, 1, 0, 4'h0, 0, 0});
        vecs.push_back('{3'd0, 32'hFFFFFFFF, 0, 0, 5'd0, 1'b1, 0, 0, 0, 4'h0, 0, 32'hFFFFFFFF});
        vecs.push_back('{3'd0, 32'h55, 0, 0, 5'd12, 1'b0, 0, 0, 0, 4'h0, 0, 32'h55});

        // Reset held with a valid aligned load on the inputs: everything stays 0.
        rst = 1'b0;
        in_valid = 1'b1;
        in_op = 3'd5;
        in_addr = 32'h100;
        in_sdata = 32'hFFFFFFFF;
        in_dest = 5'd1;
        in_we = 1'b1;
        dmem.dmemReady = 1'b0;
        dmem.dmemRdata = '0;
        #12;
        check_all_zero("reset");
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Writeback registers hold while no instruction arrives.
        run_vec('{3'd0, 32'hABCD, 0, 0, 5'd7, 1'b1, 0, 0, 0, 4'h0, 0, 32'hABCD}, 100);
        repeat (3) @(posedge clk);
        #1;
        check("hold_wen", 32'(write_enable), 32'd0);
        check("hold_waddr", 32'(write_addr), 32'd7);
        check("hold_wres", write_result, 32'hABCD);

        // Reset in the middle of an outstanding load abandons it.
        in_valid = 1'b1;
        in_op = 3'd5;
        in_addr = 32'h400;
        in_dest = 5'd9;
        in_we = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst_req_before", 32'(dmem.dmemReq), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        #2;
        rst = 1'b1;
        dmem.dmemReady = 1'b1;
        dmem.dmemRdata = 32'h12345678;
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_idle_req", 32'(dmem.dmemReq), 32'd0);
            check("midrst_idle_wen", 32'(write_enable), 32'd0);
        end
        dmem.dmemReady = 1'b0;
        @(posedge clk); #1;

        check("wb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
